// File: rtl/push_debounce_pulse.sv
// Push-button debouncer: accepts a new button level only after it has been
// sampled DEBOUNCE_CYCLES times in a row, then emits a one-cycle press or
// release strobe (gated by en) alongside the debounced level.
module push_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic sypush,
  input  logic en,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pressed_q;
  logic             press_pulse_q;
  logic             release_pulse_q;

  // Debounce FSM with registered level and strobe outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sypush) begin
            state_q <= DB_PRESS;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        DB_PRESS: begin
          if (!sypush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q       <= HELD;
            cnt_q         <= '0;
            pressed_q     <= 1'b1;
            press_pulse_q <= en;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!sypush) begin
            state_q <= DB_RELEASE;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        DB_RELEASE: begin
          if (sypush) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            pressed_q       <= 1'b0;
            release_pulse_q <= en;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_push_debounce_pulse.sv
// Testbench for push_debounce_pulse: directed scenarios plus randomized
// button activity, checked against a run-length reference model.
module tb_push_debounce_pulse;

  localparam int N = 4;

  logic clk;
  logic rst;
  logic sypush;
  logic en;
  logic pressed;
  logic press_pulse;
  logic release_pulse;

  int n_vec;
  int n_err;

  // Reference model: accepted level plus length of the current run of
  // samples that disagree with it.
  logic m_lvl;
  int   m_run;
  logic m_pp;
  logic m_rp;

  // Observed pulse tallies, used by directed scenarios
  int n_pp;
  int n_rp;

  push_debounce_pulse #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sypush       (sypush),
    .en           (en),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input logic s, input logic e, input logic r);
    m_pp = 1'b0;
    m_rp = 1'b0;
    if (r) begin
      m_lvl = 1'b0;
      m_run = 0;
    end else if (s != m_lvl) begin
      m_run++;
      if (m_run == N) begin
        m_lvl = s;
        m_run = 0;
        if (s) m_pp = e;
        else   m_rp = e;
      end
    end else begin
      m_run = 0;
    end
  endtask

  // Apply one set of inputs across one rising edge and check all outputs.
  task automatic cycle(input logic s, input logic e, input logic r);
    sypush = s;
    en     = e;
    rst    = r;
    @(posedge clk);
    model_step(s, e, r);
    #1;
    chk("pressed", int'(pressed), int'(m_lvl));
    chk("press_pulse", int'(press_pulse), int'(m_pp));
    chk("release_pulse", int'(release_pulse), int'(m_rp));
    chk("pulse_excl", int'(press_pulse & release_pulse), 0);
    if (press_pulse)   n_pp++;
    if (release_pulse) n_rp++;
  endtask

  task automatic hold(input logic s, input logic e, input int n);
    for (int i = 0; i < n; i++) cycle(s, e, 1'b0);
  endtask

  initial begin
    logic lvl;
    int   len;
    logic e;
    n_vec = 0; n_err = 0;
    m_lvl = 1'b0; m_run = 0; m_pp = 1'b0; m_rp = 1'b0;
    sypush = 1'b0; en = 1'b1; rst = 1'b1;

    // 1: reset with button held, then qualify from scratch
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    chk("rst_pressed", int'(pressed), 0);
    n_pp = 0;
    hold(1'b1, 1'b1, 3);
    chk("s1_early", n_pp, 0);
    hold(1'b1, 1'b1, 1);
    chk("s1_pp_at4", int'(press_pulse), 1);
    hold(1'b1, 1'b1, 3);
    chk("s1_npp", n_pp, 1);
    chk("s1_pressed", int'(pressed), 1);

    // 2: bounce restarts qualification
    cycle(1'b0, 1'b1, 1'b1);
    n_pp = 0;
    hold(1'b1, 1'b1, 3);
    hold(1'b0, 1'b1, 1);
    hold(1'b1, 1'b1, 3);
    chk("s2_early", n_pp, 0);
    hold(1'b1, 1'b1, 1);
    chk("s2_pp_at8", int'(press_pulse), 1);

    // 3: short glitches in both directions are ignored
    cycle(1'b0, 1'b1, 1'b1);
    n_pp = 0; n_rp = 0;
    hold(1'b1, 1'b1, 3);
    hold(1'b0, 1'b1, 3);
    chk("s3_no_press", n_pp, 0);
    hold(1'b1, 1'b1, 5);
    n_rp = 0;
    hold(1'b0, 1'b1, 3);
    hold(1'b1, 1'b1, 2);
    chk("s3_no_release", n_rp, 0);
    chk("s3_still_pressed", int'(pressed), 1);

    // 4: full press/release
    cycle(1'b0, 1'b1, 1'b1);
    n_pp = 0; n_rp = 0;
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 3);
    chk("s4_rel_early", n_rp, 0);
    hold(1'b0, 1'b1, 1);
    chk("s4_rp_at4", int'(release_pulse), 1);
    hold(1'b0, 1'b1, 6);
    chk("s4_npp", n_pp, 1);
    chk("s4_nrp", n_rp, 1);

    // 5: en low at the accepting edge loses the pulse for good
    n_pp = 0;
    hold(1'b1, 1'b0, 4);
    chk("s5_pressed", int'(pressed), 1);
    hold(1'b1, 1'b1, 6);
    chk("s5_no_pp", n_pp, 0);

    // 6: reset mid-qualification discards progress
    cycle(1'b0, 1'b1, 1'b1);
    n_pp = 0;
    hold(1'b1, 1'b1, 2);
    cycle(1'b1, 1'b1, 1'b1);
    hold(1'b1, 1'b1, 3);
    chk("s6_early", n_pp, 0);
    hold(1'b1, 1'b1, 1);
    chk("s6_pp", int'(press_pulse), 1);

    // Randomized bursts of varying length, en and occasional reset
    for (int b = 0; b < 800; b++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        e = ($urandom_range(0, 3) != 0);
        cycle(lvl, e, ($urandom_range(0, 99) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
